// File: rtl/reverb_mem_scheduler.sv
// Reverb reflection-memory scheduler.
// Each sample period issues one feedback write and then one read per tap. A tap's read address
// is the write address minus the tap delay. Taps whose history has not been written yet return
// zero. Tap results are staged internally and published on taps_o once per completed frame.
module reverb_mem_scheduler #(
    parameter int unsigned NUM    = 8,
    parameter int unsigned AWIDTH = 13,
    parameter int unsigned DWIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    sample_tick_i,
    input  logic                    enable_i,
    input  logic [NUM*AWIDTH-1:0]   delays_i,
    input  logic [DWIDTH-1:0]       wr_data_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AWIDTH-1:0]       mem_addr_o,
    output logic [DWIDTH-1:0]       mem_wrdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rdvalid_i,
    input  logic [DWIDTH-1:0]       mem_rddata_i,
    output logic [NUM*DWIDTH-1:0]   taps_o,
    output logic                    frame_valid_o,
    output logic                    overrun_o,
    output logic                    busy_o
);

    localparam int unsigned TW = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_TICK = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] RD_REQ    = 3'd3;
    localparam logic [2:0] RD_WAIT   = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0]              state, state_nx;
    logic [AWIDTH-1:0]       wr_addr, wr_addr_nx;
    logic [AWIDTH-1:0]       fill_cnt, fill_cnt_nx;
    logic [TW-1:0]           tap_idx, tap_idx_nx;
    logic [NUM*AWIDTH-1:0]   delays, delays_nx;
    logic [NUM*DWIDTH-1:0]   stage, stage_nx;
    logic [NUM*DWIDTH-1:0]   taps_nx;
    logic                    req_nx, we_nx, fv_nx, ovr_nx;
    logic [AWIDTH-1:0]       addr_nx;
    logic [DWIDTH-1:0]       wrdata_nx;

    logic [AWIDTH-1:0]       cur_delay;
    logic                    skip_tap;
    logic                    last_tap;
    logic                    tap_done;

    // Busy covers every state that belongs to a frame in flight.
    assign busy_o = (state != IDLE) && (state != WAIT_TICK);

    // Per-tap decode: disabled taps and taps reaching past the filled history are skipped.
    always_comb begin
        cur_delay = delays[tap_idx*AWIDTH +: AWIDTH];
        skip_tap  = (cur_delay == '0) || (fill_cnt < cur_delay);
        last_tap  = (tap_idx == TW'(NUM - 1));
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_nx    = state;
        wr_addr_nx  = wr_addr;
        fill_cnt_nx = fill_cnt;
        tap_idx_nx  = tap_idx;
        delays_nx   = delays;
        stage_nx    = stage;
        taps_nx     = taps_o;
        req_nx      = mem_req_o;
        we_nx       = mem_we_o;
        addr_nx     = mem_addr_o;
        wrdata_nx   = mem_wrdata_o;
        fv_nx       = 1'b0;
        ovr_nx      = sample_tick_i && busy_o;
        tap_done    = 1'b0;

        case (state)
            IDLE: begin
                if (enable_i) state_nx = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable_i) begin
                    state_nx    = IDLE;
                    fill_cnt_nx = '0;
                    taps_nx     = '0;
                end else if (sample_tick_i) begin
                    delays_nx  = delays_i;
                    wrdata_nx  = wr_data_i;
                    tap_idx_nx = '0;
                    req_nx     = 1'b1;
                    we_nx      = 1'b1;
                    addr_nx    = wr_addr;
                    state_nx   = WRITE;
                end
            end
            WRITE: begin
                if (mem_gnt_i) begin
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    state_nx = RD_REQ;
                end
            end
            RD_REQ: begin
                // First cycle decides the tap; a raised request then waits here for its grant.
                if (mem_req_o) begin
                    if (mem_gnt_i) begin
                        req_nx   = 1'b0;
                        state_nx = RD_WAIT;
                    end
                end else if (skip_tap) begin
                    stage_nx[tap_idx*DWIDTH +: DWIDTH] = '0;
                    tap_done = 1'b1;
                end else begin
                    req_nx  = 1'b1;
                    we_nx   = 1'b0;
                    addr_nx = wr_addr - cur_delay;
                end
            end
            RD_WAIT: begin
                if (mem_rdvalid_i) begin
                    stage_nx[tap_idx*DWIDTH +: DWIDTH] = mem_rddata_i;
                    tap_done = 1'b1;
                end
            end
            DONE: begin
                wr_addr_nx = wr_addr + 1'b1;
                if (fill_cnt != '1) fill_cnt_nx = fill_cnt + 1'b1;
                state_nx = WAIT_TICK;
            end
            default: state_nx = IDLE;
        endcase

        // Publish the staged vector together with the frame_valid pulse so both appear in DONE.
        if (tap_done) begin
            if (last_tap) begin
                state_nx = DONE;
                fv_nx    = 1'b1;
                taps_nx  = stage_nx;
            end else begin
                tap_idx_nx = tap_idx + 1'b1;
                state_nx   = RD_REQ;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state         <= IDLE;
            wr_addr       <= '0;
            fill_cnt      <= '0;
            tap_idx       <= '0;
            delays        <= '0;
            stage         <= '0;
            taps_o        <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wrdata_o  <= '0;
            frame_valid_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            state         <= state_nx;
            wr_addr       <= wr_addr_nx;
            fill_cnt      <= fill_cnt_nx;
            tap_idx       <= tap_idx_nx;
            delays        <= delays_nx;
            stage         <= stage_nx;
            taps_o        <= taps_nx;
            mem_req_o     <= req_nx;
            mem_we_o      <= we_nx;
            mem_addr_o    <= addr_nx;
            mem_wrdata_o  <= wrdata_nx;
            frame_valid_o <= fv_nx;
            overrun_o     <= ovr_nx;
        end
    end

endmodule

// File: tb/tb_reverb_mem_scheduler.sv
// Scoreboard bench for reverb_mem_scheduler (NUM=2, AWIDTH=4, DWIDTH=16).
// Expected tap vectors are queued when a frame is started; a monitor pops them on frame_valid_o.
module tb_reverb_mem_scheduler;

    localparam int unsigned NUM    = 2;
    localparam int unsigned AWIDTH = 4;
    localparam int unsigned DWIDTH = 16;

    logic                  clk = 1'b0;
    logic                  arst_n = 1'b0;
    logic                  tick = 1'b0;
    logic                  enable = 1'b0;
    logic [NUM*AWIDTH-1:0] delays = '0;
    logic [DWIDTH-1:0]     wr_data = '0;
    logic                  mem_req, mem_we;
    logic [AWIDTH-1:0]     mem_addr;
    logic [DWIDTH-1:0]     mem_wrdata;
    logic                  mem_gnt = 1'b0;
    logic                  mem_rdvalid = 1'b0;
    logic [DWIDTH-1:0]     mem_rddata = '0;
    logic [NUM*DWIDTH-1:0] taps;
    logic                  frame_valid, overrun, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_seen = 0;
    int ovr_seen = 0;
    logic [NUM*DWIDTH-1:0] exp_q[$];

    // Memory model state
    logic [DWIDTH-1:0] mem_model [16];
    int gnt_dly = 0;
    int rd_lat = 1;
    int held = 0;
    int rd_cnt = 0;
    logic [DWIDTH-1:0] rd_buf = '0;
    logic [AWIDTH-1:0] last_rd_addr = '0;
    logic [AWIDTH-1:0] last_wr_addr = '0;
    logic [AWIDTH+DWIDTH:0] held_cmd = '0;

    reverb_mem_scheduler #(.NUM(NUM), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .sample_tick_i (tick),
        .enable_i      (enable),
        .delays_i      (delays),
        .wr_data_i     (wr_data),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wrdata_o  (mem_wrdata),
        .mem_gnt_i     (mem_gnt),
        .mem_rdvalid_i (mem_rdvalid),
        .mem_rddata_i  (mem_rddata),
        .taps_o        (taps),
        .frame_valid_o (frame_valid),
        .overrun_o     (overrun),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Memory responder: grants after gnt_dly waiting cycles, returns read data rd_lat cycles later.
    initial begin
        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rdvalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rdvalid = 1'b1;
                    mem_rddata = rd_buf;
                end
            end
            if (mem_req) begin
                if (held == 0) held_cmd = {mem_we, mem_addr, mem_wrdata};
                else check("req_hold", 64'({mem_we, mem_addr, mem_wrdata}), 64'(held_cmd));
                if (held == gnt_dly) begin
                    mem_gnt = 1'b1;
                    held = 0;
                    if (mem_we) begin
                        mem_model[mem_addr] = mem_wrdata;
                        last_wr_addr = mem_addr;
                    end else begin
                        rd_buf = mem_model[mem_addr];
                        last_rd_addr = mem_addr;
                        rd_cnt = rd_lat;
                    end
                end else begin
                    held++;
                end
            end else begin
                held = 0;
            end
        end
    end

    // Monitor: compare taps_o against the scoreboard on every frame_valid_o pulse.
    initial begin
        logic [NUM*DWIDTH-1:0] e;
        forever begin
            @(negedge clk);
            if (overrun) ovr_seen++;
            if (frame_valid) begin
                frame_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: taps_o=%h, no frame expected", taps);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_taps", 64'(taps), 64'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        arst_n = 1'b0;
        enable = 1'b0;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick(input logic [DWIDTH-1:0] d);
        @(posedge clk);
        #1 tick = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        for (int i = 0; i < 300 && frame_seen < target; i++) @(posedge clk);
        if (frame_seen < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frame_seen, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [DWIDTH-1:0] d, input logic [DWIDTH-1:0] e0,
                             input logic [DWIDTH-1:0] e1, input bit drop_en);
        int target;
        target = frame_seen + 1;
        exp_q.push_back({e1, e0});
        pulse_tick(d);
        if (drop_en) begin
            repeat (2) @(posedge clk);
            #1 enable = 1'b0;
        end
        wait_frame(target);
    endtask

    initial begin
        int f0, o0, req_hits;
        logic [DWIDTH-1:0] e0;

        // Reset values
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 64'(mem_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_taps", 64'(taps), 64'd0);
        check("rst_misc", 64'({mem_we, mem_addr, mem_wrdata, frame_valid, overrun}), 64'd0);

        // Fill-in: delays tap0=1, tap1=3
        do_reset();
        gnt_dly = 0; rd_lat = 1;
        delays = {4'd3, 4'd1};
        enable = 1'b1;
        @(posedge clk);
        run_frame(16'd100, 16'd0,   16'd0,   1'b0);
        run_frame(16'd200, 16'd100, 16'd0,   1'b0);
        run_frame(16'd300, 16'd200, 16'd0,   1'b0);
        run_frame(16'd400, 16'd300, 16'd100, 1'b0);

        // Stalled memory: grants 4 cycles late, read data 3 cycles after grant
        do_reset();
        gnt_dly = 4; rd_lat = 3;
        delays = {4'd2, 4'd1};
        enable = 1'b1;
        @(posedge clk);
        run_frame(16'd7, 16'd0, 16'd0, 1'b0);
        run_frame(16'd8, 16'd7, 16'd0, 1'b0);
        run_frame(16'd9, 16'd8, 16'd7, 1'b0);

        // Overrun: second tick 5 cycles into a frame with real reads
        do_reset();
        gnt_dly = 0; rd_lat = 1;
        delays = {4'd1, 4'd1};
        enable = 1'b1;
        @(posedge clk);
        run_frame(16'd55, 16'd0, 16'd0, 1'b0);
        o0 = ovr_seen;
        f0 = frame_seen;
        exp_q.push_back({16'd55, 16'd55});
        @(posedge clk);
        #1 tick = 1'b1; wr_data = 16'd66;
        @(posedge clk);
        #1 tick = 1'b0;
        repeat (4) @(posedge clk);
        #1 tick = 1'b1; wr_data = 16'd99;
        @(posedge clk);
        #1 tick = 1'b0;
        wait_frame(f0 + 1);
        repeat (20) @(posedge clk);
        check("overrun_pulses", 64'(ovr_seen - o0), 64'd1);
        check("overrun_frames", 64'(frame_seen - f0), 64'd1);
        run_frame(16'd77, 16'd66, 16'd66, 1'b0);
        check("wr_addr_after_overrun", 64'(last_wr_addr), 64'd2);

        // Disable mid-frame, then re-enable with fill restarting
        do_reset();
        delays = {4'd0, 4'd1};
        enable = 1'b1;
        @(posedge clk);
        run_frame(16'd11, 16'd0,  16'd0, 1'b0);
        run_frame(16'd22, 16'd11, 16'd0, 1'b0);
        run_frame(16'd33, 16'd22, 16'd0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("disable_busy", 64'(busy), 64'd0);
        check("disable_taps", 64'(taps), 64'd0);
        check("disable_req", 64'(mem_req), 64'd0);
        enable = 1'b1;
        @(posedge clk);
        run_frame(16'd44, 16'd0,  16'd0, 1'b0);
        run_frame(16'd55, 16'd44, 16'd0, 1'b0);

        // Reset during RD_WAIT
        do_reset();
        gnt_dly = 0; rd_lat = 3;
        delays = {4'd0, 4'd1};
        enable = 1'b1;
        @(posedge clk);
        run_frame(16'd5, 16'd0, 16'd0, 1'b0);
        run_frame(16'd6, 16'd5, 16'd0, 1'b0);
        pulse_tick(16'd7);
        req_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (mem_req && !mem_we && mem_gnt) begin
                req_hits = 1;
                break;
            end
        end
        check("rd_gnt_seen", 64'(req_hits), 64'd1);
        @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        check("midrst_taps", 64'(taps), 64'd0);
        check("midrst_outs", 64'({mem_req, mem_we, mem_addr, mem_wrdata, frame_valid, overrun,
                                  busy}), 64'd0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        req_hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) req_hits++;
        end
        check("midrst_no_req", 64'(req_hits), 64'd0);
        rd_lat = 1;
        run_frame(16'd9, 16'd0, 16'd0, 1'b0);

        // Address wrap: 18 frames with delay 5 on tap0; frame 18 reads (1-5) mod 16 = 12
        do_reset();
        gnt_dly = 0; rd_lat = 1;
        delays = {4'd0, 4'd5};
        enable = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            e0 = (k >= 6) ? DWIDTH'(1000 + k - 5) : '0;
            run_frame(DWIDTH'(1000 + k), e0, 16'd0, 1'b0);
        end
        check("wrap_rd_addr", 64'(last_rd_addr), 64'd12);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
